// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FAULT state only exists when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          JUMP_FIELD_W   = 26;
    localparam int          IMM_W          = 16;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;
`endif

    // Branch offset: sign-extended word displacement turned into a byte offset.
    function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage: jr, then jump/jal,
// then taken bne, otherwise fall through to pc + 4.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        ctrl_branch,
    input  logic        ctrl_jump,
    input  logic        ctrl_jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    assign unused_opcode = ^instr[31:JUMP_FIELD_W];

    always_comb begin
        next_pc = pc_plus4;
        if (ctrl_jr) begin
            next_pc = rs_data;
        end else if (ctrl_jump) begin
            next_pc = {pc_plus4[31:28], instr[JUMP_FIELD_W-1:0], 2'b00};
        end else if (ctrl_branch && !alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over
// req/ack, and hands it to the decoder over valid/ready.
// Optional misaligned-target trap: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ctrl_branch,
    input  logic        ctrl_jump,
    input  logic        ctrl_jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic        fetch_fault
);

    fetch_state_t state;
    logic [31:0]  raw_next_pc;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc (
        .pc          (pc),
        .instr       (instr),
        .ctrl_branch (ctrl_branch),
        .ctrl_jump   (ctrl_jump),
        .ctrl_jr     (ctrl_jr),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .next_pc     (raw_next_pc)
    );

    assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;

    assign next_pc    = raw_next_pc;
    assign misaligned = |raw_next_pc[1:0];
`else
    // Without the trap, a misaligned target is silently rounded down to a word.
    logic unused_low_bits;

    assign next_pc         = {raw_next_pc[31:2], 2'b00};
    assign unused_low_bits = ^raw_next_pc[1:0];
    assign fetch_fault     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_plus4    <= RESET_PC + 32'd4;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        pc_plus4    <= next_pc + 32'd4;
                        instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end
`else
                        state    <= REQ;
                        imem_req <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                FAULT: begin
                    state <= FAULT;
                end
`endif
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cases plus randomized
// fetches checked against a behavioural next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ctrl_branch;
    logic        ctrl_jump;
    logic        ctrl_jr;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic        fetch_fault;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] modelPc;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ctrl_branch (ctrl_branch),
        .ctrl_jump   (ctrl_jump),
        .ctrl_jr     (ctrl_jr),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference next-PC taken straight from the architectural rules.
    function automatic logic [31:0] modelNext(input logic [31:0] p, input logic [31:0] word,
                                              input logic br, input logic jp, input logic jr,
                                              input logic z, input logic [31:0] rs);
        logic [31:0] link;
        logic [31:0] t;
        int          off;
        link = p + 32'd4;
        off  = $signed(word[15:0]);
        if (jr)
            t = rs;
        else if (jp)
            t = (link & 32'hF000_0000) | ({6'b0, word[25:0]} * 32'd4);
        else if (br && !z)
            t = link + 32'(off * 4);
        else
            t = link;
`ifndef FETCH_ALIGN_CHECK_EN
        t = t & ~32'h3;
`endif
        return t;
    endfunction

    // One full fetch: request wait, ack, decoder stall, then handshake.
    task automatic applyStimulus(input int ackDelay, input int stall, input logic [31:0] word,
                                 input logic br, input logic jp, input logic jr,
                                 input logic z, input logic [31:0] rs);
        logic [31:0] target;
        checkOutput("req_high", 32'(imem_req), 32'd1);
        checkOutput("req_addr", imem_addr, modelPc);
        for (int i = 0; i < ackDelay; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("req_wait", 32'(imem_req), 32'd1);
            checkOutput("addr_wait", imem_addr, modelPc);
            checkOutput("valid_wait", 32'(instr_valid), 32'd0);
            checkOutput("pc_wait", pc, modelPc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("valid_rise", 32'(instr_valid), 32'd1);
        checkOutput("instr_capture", instr, word);
        checkOutput("pc_hold", pc, modelPc);
        checkOutput("pc_plus4_hold", pc_plus4, modelPc + 32'd4);
        checkOutput("req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            ctrl_jr     = 1'($urandom_range(0, 1));
            rs_data     = $urandom;
            @(negedge clk);
            checkOutput("valid_stall", 32'(instr_valid), 32'd1);
            checkOutput("instr_stall", instr, word);
            checkOutput("pc_stall", pc, modelPc);
            checkOutput("req_stall", 32'(imem_req), 32'd0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        ctrl_branch = br;
        ctrl_jump   = jp;
        ctrl_jr     = jr;
        alu_zero    = z;
        rs_data     = rs;
        target      = modelNext(modelPc, word, br, jp, jr, z, rs);
        @(negedge clk);
        instr_ready = 1'b0;
        ctrl_branch = 1'b0;
        ctrl_jump   = 1'b0;
        ctrl_jr     = 1'b0;
        alu_zero    = 1'b0;
        checkOutput("valid_fall", 32'(instr_valid), 32'd0);
        checkOutput("next_pc", pc, target);
        checkOutput("pc_plus4_next", pc_plus4, target + 32'd4);
        if (target[1:0] == 2'b00)
            checkOutput("no_fault", 32'(fetch_fault), 32'd0);
        modelPc = target;
    endtask

    initial begin
        logic [31:0] rs;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        ctrl_branch = 1'b0;
        ctrl_jump   = 1'b0;
        ctrl_jr     = 1'b0;
        alu_zero    = 1'b0;
        rs_data     = 32'h0;
        modelPc     = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential fetch, then bne back and not taken, then stalls.
        applyStimulus(0, 0, 32'h2000_0001, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h2000_0002, 0, 0, 0, 0, 32'h0);
        checkOutput("seq_addr8", imem_addr, 32'h8);
        applyStimulus(0, 0, {6'h05, 5'd1, 5'd2, 16'hFFFE}, 1, 0, 0, 0, 32'h0);
        checkOutput("bne_taken_addr", imem_addr, 32'h4);
        applyStimulus(0, 0, 32'h2000_0003, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, {6'h05, 5'd1, 5'd2, 16'hFFFE}, 1, 0, 0, 1, 32'h0);
        checkOutput("bne_not_taken_addr", imem_addr, 32'hC);
        applyStimulus(3, 4, 32'h2000_0004, 0, 0, 0, 0, 32'h0);
        checkOutput("stall_advance_once", imem_addr, 32'h10);

        // jal and jr targets.
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'h1000_0000);
        applyStimulus(1, 1, {6'h03, 26'h40}, 0, 1, 0, 0, 32'h0);
        checkOutput("jal_addr", imem_addr, 32'h1000_0100);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'h200);
        checkOutput("jr_addr", imem_addr, 32'h200);

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFC);
        checkOutput("wrap_plus4", pc_plus4, 32'h0);
        applyStimulus(0, 0, 32'h2000_0005, 0, 0, 0, 0, 32'h0);
        checkOutput("wrap_addr", imem_addr, 32'h0);

        for (int n = 0; n < 40; n++) begin
            rs = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rs[1:0] = 2'b00;
`endif
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rs);
        end

        // Reset while an instruction is held, with an ack still pending.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("pre_reset_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", 32'(imem_req), 32'd0);
        checkOutput("async_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("async_rst_pc", pc, 32'h0);
        checkOutput("async_rst_instr", instr, 32'h0);
        @(negedge clk);
        checkOutput("rst_hold_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        modelPc = 32'h0;
        checkOutput("restart_req", 32'(imem_req), 32'd1);
        checkOutput("restart_addr", imem_addr, 32'h0);

        // Misaligned jr target.
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'h203);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("fault_set", 32'(fetch_fault), 32'd1);
        checkOutput("fault_pc", pc, 32'h203);
        for (int i = 0; i < 4; i++) begin
            imem_ack    = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("fault_req", 32'(imem_req), 32'd0);
            checkOutput("fault_valid", 32'(instr_valid), 32'd0);
            checkOutput("fault_sticky", 32'(fetch_fault), 32'd1);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        checkOutput("fault_cleared", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("fault_restart_req", 32'(imem_req), 32'd1);
`else
        checkOutput("misalign_addr", imem_addr, 32'h200);
        checkOutput("misalign_no_fault", 32'(fetch_fault), 32'd0);
        checkOutput("misalign_req", 32'(imem_req), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage sitting directly upstream of the instruction decoder in the single-cycle CPU. It holds the PC and issues one-outstanding word reads to instruction memory through a req/ack handshake. It presents the fetched word to the decoder with a valid/ready handshake, then computes the next PC from the decoder's branch/jump/jr control outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; equals pc.
- imem_ack  in  1  memory response; may assert in the same cycle as imem_req or any later cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- instr  out  32  held instruction, feeds the decoder.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  downstream consumes instr this cycle.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc + 4, used as the jal link value.
- ctrl_branch, ctrl_jump, ctrl_jr  in  1 each  decoder control for the held instr.
- alu_zero  in  1  ALU zero flag for the held instr.
- rs_data  in  32  register rs value, used as the jr target.
- fetch_fault  out  1  misaligned-target fault; see Configuration.

## Operation
- States: IDLE, REQ, HOLD, FAULT (FAULT only exists with the macro defined).
- IDLE: entered on reset. Moves to REQ on the next edge.
- REQ: imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack, instr <= imem_rdata and the FSM moves to HOLD.
- HOLD: instr_valid=1 and instr is held stable.
  - With instr_ready=1, the handshake completes: pc <= next_pc and the FSM moves to REQ.
  - With instr_ready=0, the FSM stays in HOLD. instr, pc, and instr_valid are unchanged.
- next_pc priority, evaluated only on handshake completion:
  1. ctrl_jr: rs_data.
  2. ctrl_jump: {pc_plus4[31:28], instr[25:0], 2'b00}. The jal case is covered here because the decoder asserts jump for jal.
  3. ctrl_branch && !alu_zero (bne taken): pc_plus4 + (sext(instr[15:0]) << 2).
  4. Otherwise: pc_plus4.
- All PC arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC wraps to 0.
- Only one request is outstanding at a time. An imem_ack outside REQ is ignored.
- Reset mid-operation:
  - Immediately: the FSM goes to IDLE, imem_req=0, instr_valid=0.
  - pc=RESET_PC.
  - A pending ack is dropped.

## Timing
- Reset values:
  - pc = RESET_PC, pc_plus4 = RESET_PC + 4.
  - instr = 0, instr_valid = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - fetch_fault = 0, state = IDLE.
- First imem_req rises in the first cycle after rst_n deasserts.
- With a zero-wait ack and instr_ready held at 1, the throughput is one instruction per 2 cycles.
- instr_valid rises the cycle after the ack edge.
- imem_ack arriving N cycles late adds N cycles.
- pc and pc_plus4 change only on handshake completion.
- instr_valid falls in the cycle after the handshake.
- Outputs are registered. next_pc is combinational from the inputs sampled in HOLD.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - If next_pc[1:0] != 0 at handshake, pc <= the misaligned value and the FSM enters FAULT.
  - In FAULT: imem_req=0, instr_valid=0, fetch_fault=1.
  - FAULT is sticky until rst_n.
- Undefined:
  - next_pc[1:0] is forced to 2'b00.
  - The FAULT state is absent and fetch_fault is tied 0 (the port remains present).

## Structure
- Package fetch_pkg holds:
  - the state enum (fetch_state_t),
  - the RESET_PC default,
  - localparams for the jump field widths (26) and the immediate width (16).
- Sub-module next_pc_calc: purely combinational; inputs pc, instr, control, alu_zero, rs_data; output next_pc. The FSM and registers stay in instr_fetch_unit.

## Test plan
- Reset/start:
  - Stimulus: hold rst_n=0, then release.
  - Response: pc=0 and imem_req=0 while reset is held. Release → imem_req=1, imem_addr=0 one cycle later.
- Sequential fetch:
  - Stimulus: ack same cycle, instr_ready=1, no control.
  - Response: imem_addr sequence 0,4,8,12, with a new address every 2 cycles.
- Stalls:
  - Stimulus: ack delayed 3 cycles; instr_ready low for 4 cycles.
  - Response: imem_addr/instr/pc remain stable throughout; the advance happens exactly once.
- Branch:
  - Stimulus: bne at pc=8 with imm16=16'hFFFE and alu_zero=0.
  - Response: next imem_addr=4.
  - Stimulus: same instruction with alu_zero=1.
  - Response: next imem_addr=12.
- Jump/jr:
  - Stimulus: jal at pc=32'h1000_0000 with instr[25:0]=26'h40.
  - Response: next imem_addr=32'h1000_0100, pc_plus4=32'h1000_0004 during HOLD.
  - Stimulus: jr with rs_data=32'h200.
  - Response: next imem_addr=32'h200.
- Misalignment:
  - Stimulus: jr with rs_data=32'h203.
  - With FETCH_ALIGN_CHECK_EN: fetch_fault=1, imem_req stays 0 until reset.
  - Without it: next imem_addr=32'h200.
